// File: rtl/dec_char_to_bin_h20.sv
// Sequential ASCII decimal-string parser, one character per clock, committing
// a class/sign/significand/exponent record into a 16-entry semaphored buffer.
module dec_char_to_bin_h20 #(
    parameter int NCHARS = 34,
    parameter int SIGDIG = 20
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                wren,
    input  logic [3:0]          wraddrs,
    input  logic [8*NCHARS-1:0] wrdata,
    input  logic                rden,
    input  logic [3:0]          rdaddrs,
    output logic [88:0]         rddata,
    output logic                ready,
    output logic                busy,
    output logic                overrun
);

    typedef enum logic [2:0] {IDLE, SIGN, INT, FRAC, EXPS, EXPD, WORD, COMMIT} state_t;

    typedef struct packed {
        logic [1:0]  cls;
        logic        sign;
        logic        invalid;
        logic        inexact;
        logic [15:0] expo;
        logic [67:0] sig;
    } rec_t;

    state_t                state, state_n;
    logic [8*NCHARS-1:0]   chars, chars_n;
    logic [3:0]            addr, addr_n;
    logic                  sign, sign_n;
    logic [67:0]           sig, sig_n;
    logic [4:0]            ndig, ndig_n;
    logic                  mant, mant_n;
    logic [15:0]           adj, adj_n;
    logic                  inex, inex_n;
    logic                  esign, esign_n;
    logic [13:0]           eval, eval_n;
    logic [2:0]            edig, edig_n;
    logic [2:0]            wmask, wmask_n, wmask_step;
    logic [2:0]            wpos, wpos_n;
    logic [1:0]            cls, cls_n;
    logic                  inv, inv_n;

    logic [7:0]            cur, lc;
    logic                  is_nul, is_dig, sig_full;
    logic [3:0]            dval;
    logic [67:0]           sig_mac;
    logic [13:0]           eval_mac;
    logic                  take_dig, in_frac, take_edig, word_step, bad;
    logic                  word_done;
    logic [1:0]            word_cls;
    logic [15:0]           eexp, exp_fin;
    rec_t                  rec;

    rec_t                  mem [16];
    logic [15:0]           semaphor;

    // Candidate words: 0 = "inf", 1 = "nan", 2 = "snan"; 0 past the end never matches.
    function automatic logic [7:0] wch(input logic [1:0] w, input logic [2:0] p);
        case ({w, p})
            5'b00_000: wch = "i";
            5'b00_001: wch = "n";
            5'b00_010: wch = "f";
            5'b01_000: wch = "n";
            5'b01_001: wch = "a";
            5'b01_010: wch = "n";
            5'b10_000: wch = "s";
            5'b10_001: wch = "n";
            5'b10_010: wch = "a";
            5'b10_011: wch = "n";
            default:   wch = 8'h00;
        endcase
    endfunction

    // Shifting zeros in makes the slot after char NCHARS-1 read as NUL.
    assign cur      = chars[8*NCHARS-1 -: 8];
    assign lc       = (cur >= 8'h41 && cur <= 8'h5A) ? (cur | 8'h20) : cur;
    assign is_nul   = (cur == 8'h00);
    assign is_dig   = (cur >= "0") && (cur <= "9");
    assign dval     = cur[3:0];
    assign sig_full = (ndig == 5'(SIGDIG));
    assign sig_mac  = {sig[64:0], 3'b000} + {sig[66:0], 1'b0} + {64'd0, dval};
    assign eval_mac = {eval[10:0], 3'b000} + {eval[12:0], 1'b0} + {10'd0, dval};

    always_comb begin
        for (int w = 0; w < 3; w++)
            wmask_step[w] = wmask[w] && (wch(2'(w), wpos) == lc);
    end

    assign word_done = (wmask[0] && wpos == 3'd3) || (wmask[1] && wpos == 3'd3) ||
                       (wmask[2] && wpos == 3'd4);
    assign word_cls  = (wmask[2] && wpos == 3'd4) ? 2'b11 :
                       (wmask[0] && wpos == 3'd3) ? 2'b01 : 2'b10;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        chars_n   = chars;
        addr_n    = addr;
        sign_n    = sign;
        sig_n     = sig;
        ndig_n    = ndig;
        mant_n    = mant;
        adj_n     = adj;
        inex_n    = inex;
        esign_n   = esign;
        eval_n    = eval;
        edig_n    = edig;
        wmask_n   = wmask;
        wpos_n    = wpos;
        cls_n     = cls;
        inv_n     = inv;
        take_dig  = 1'b0;
        in_frac   = 1'b0;
        take_edig = 1'b0;
        word_step = 1'b0;
        bad       = 1'b0;
        if (state != IDLE && state != COMMIT)
            chars_n = {chars[8*NCHARS-9:0], 8'h00};
        case (state)
            IDLE: if (wren) begin
                state_n = SIGN;
                chars_n = wrdata;
                addr_n  = wraddrs;
                sign_n  = 1'b0;
                sig_n   = '0;
                ndig_n  = '0;
                mant_n  = 1'b0;
                adj_n   = '0;
                inex_n  = 1'b0;
                esign_n = 1'b0;
                eval_n  = '0;
                edig_n  = '0;
                wmask_n = 3'b111;
                wpos_n  = '0;
                cls_n   = 2'b00;
                inv_n   = 1'b0;
            end
            SIGN: begin
                if (is_nul)           bad = 1'b1;
                else if (cur == "+")  state_n = INT;
                else if (cur == "-")  begin sign_n = 1'b1; state_n = INT; end
                else if (is_dig)      begin take_dig = 1'b1; state_n = INT; end
                else if (cur == ".")  state_n = FRAC;
                else                  word_step = 1'b1;
            end
            INT: begin
                if (is_nul)           begin if (mant) state_n = COMMIT; else bad = 1'b1; end
                else if (is_dig)      take_dig = 1'b1;
                else if (cur == ".")  state_n = FRAC;
                else if (mant)        begin if (lc == "e") state_n = EXPS; else bad = 1'b1; end
                else                  word_step = 1'b1;
            end
            FRAC: begin
                if (is_nul)                   begin if (mant) state_n = COMMIT; else bad = 1'b1; end
                else if (is_dig)              begin take_dig = 1'b1; in_frac = 1'b1; end
                else if (lc == "e" && mant)   state_n = EXPS;
                else                          bad = 1'b1;
            end
            EXPS: begin
                if (cur == "+")       state_n = EXPD;
                else if (cur == "-")  begin esign_n = 1'b1; state_n = EXPD; end
                else if (is_dig)      begin take_edig = 1'b1; state_n = EXPD; end
                else                  bad = 1'b1;
            end
            EXPD: begin
                if (is_nul)           begin if (edig == 3'd0) bad = 1'b1; else state_n = COMMIT; end
                else if (is_dig)      take_edig = 1'b1;
                else                  bad = 1'b1;
            end
            WORD: begin
                if (is_nul)           begin
                    if (word_done) begin cls_n = word_cls; state_n = COMMIT; end
                    else bad = 1'b1;
                end
                else                  word_step = 1'b1;
            end
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Leading zeros only move the exponent when they sit after the point.
        if (take_dig) begin
            mant_n = 1'b1;
            if (ndig == 5'd0 && dval == 4'd0) begin
                if (in_frac) adj_n = adj - 16'd1;
            end else if (!sig_full) begin
                sig_n  = sig_mac;
                ndig_n = ndig + 5'd1;
                if (in_frac) adj_n = adj - 16'd1;
            end else begin
                if (!in_frac)      adj_n  = adj + 16'd1;
                if (dval != 4'd0)  inex_n = 1'b1;
            end
        end
        if (take_edig) begin
            if (edig == 3'd4) bad = 1'b1;
            else begin
                eval_n = eval_mac;
                edig_n = edig + 3'd1;
            end
        end
        if (word_step) begin
            if (wmask_step == 3'b000) bad = 1'b1;
            else begin
                wmask_n = wmask_step;
                wpos_n  = wpos + 3'd1;
                state_n = WORD;
            end
        end
        if (bad) begin
            inv_n   = 1'b1;
            state_n = COMMIT;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            chars <= '0;
            addr  <= '0;
            sign  <= 1'b0;
            sig   <= '0;
            ndig  <= '0;
            mant  <= 1'b0;
            adj   <= '0;
            inex  <= 1'b0;
            esign <= 1'b0;
            eval  <= '0;
            edig  <= '0;
            wmask <= 3'b111;
            wpos  <= '0;
            cls   <= 2'b00;
            inv   <= 1'b0;
        end else begin
            chars <= chars_n;
            addr  <= addr_n;
            sign  <= sign_n;
            sig   <= sig_n;
            ndig  <= ndig_n;
            mant  <= mant_n;
            adj   <= adj_n;
            inex  <= inex_n;
            esign <= esign_n;
            eval  <= eval_n;
            edig  <= edig_n;
            wmask <= wmask_n;
            wpos  <= wpos_n;
            cls   <= cls_n;
            inv   <= inv_n;
        end
    end

    assign eexp    = esign ? (16'd0 - {2'b00, eval}) : {2'b00, eval};
    assign exp_fin = adj + eexp;

    always_comb begin
        rec = '0;
        if (inv) begin
            rec.cls     = 2'b10;
            rec.invalid = 1'b1;
        end else if (cls != 2'b00) begin
            rec.cls  = cls;
            rec.sign = sign;
        end else begin
            rec.sign    = sign;
            rec.inexact = inex;
            rec.expo    = exp_fin;
            rec.sig     = sig;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (state == COMMIT) mem[addr] <= rec;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            semaphor <= 16'hFFFF;
        end else begin
            if (state == IDLE && wren) semaphor[wraddrs] <= 1'b0;
            if (state == COMMIT)       semaphor[addr]    <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rddata  <= '0;
            ready   <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (rden) rddata <= mem[rdaddrs];
            ready   <= rden ? semaphor[rdaddrs] : 1'b1;
            overrun <= wren && busy;
        end
    end

endmodule

// File: doc/dec_char_to_bin_h20.md
# dec_char_to_bin_h20

Sequential decimal-character parser for the H=20 conversion family. It is the inbound counterpart of the binary-to-decimal-character converter: it accepts a 34-character ASCII decimal string in the same 272-bit layout and parses it one character per clock. The output is an intermediate record of class, sign, binary integer significand, signed decimal exponent and flags. Each record is committed to a 16-entry result buffer whose per-address semaphore drives `ready`, matching the existing func-unit read protocol.

## Interface
- `NCHARS`, 34: characters per input word.
- `SIGDIG`, 20: maximum significant digits retained (H=20).
- `CLK`  in  1  clock; all state changes on rising edge.
- `RESET`  in  1  reset, asynchronous, active-low.
- `wren`  in  1  write strobe; starts a parse job when accepted.
- `wraddrs`  in  4  result-buffer address for the job.
- `wrdata`  in  272  ASCII string; char 0 = `[271:264]`, char 33 = `[7:0]`.
- `rden`  in  1  read strobe.
- `rdaddrs`  in  4  read address.
- `rddata`  out  89  registered record: `[88:87]` class (00 finite, 01 inf, 10 qNaN, 11 sNaN), `[86]` sign, `[85]` invalid, `[84]` inexact, `[83:68]` exp (2's complement), `[67:0]` sig.
- `ready`  out  1  registered: semaphore of `rdaddrs` when `rden`, else 1.
- `busy`  out  1  job in progress; `wren` ignored while high.
- `overrun`  out  1  one-cycle pulse when `wren` arrives while busy.

## Operation
- States:
  - IDLE
  - SIGN (char 0: optional `+`/`-`)
  - INT
  - FRAC
  - EXPS (optional exponent sign)
  - EXPD
  - WORD (match `inf`, `nan`, `snan`, case-insensitive)
  - COMMIT
- Accept: in IDLE, `wren` latches `wrdata` and `wraddrs`, clears `semaphor[wraddrs]`, sets `busy`.
- Terminator is NUL (8'h00) or end of char 33. It moves SIGN/INT/FRAC/EXPD/WORD to COMMIT.
- Digits:
  - Leading zeros are not significant.
  - Significant digits accumulate `sig = sig*10 + d`, up to SIGDIG digits; 10^20 < 2^68.
  - Each retained fraction digit, including leading zeros, decrements the exponent adjust.
  - Dropped integer digits increment it.
  - A dropped digit that is non-zero sets inexact.
- Exponent: `e`/`E`, optional sign, then 1–4 digits; `exp = ±explicit + adjust`. The result always fits in 16 bits.
- Invalid: any of the following gives class qNaN, invalid=1, sig=0, exp=0, sign=0, and goes to COMMIT next cycle:
  - a character outside the grammar
  - a second `.`
  - no mantissa digits
  - `e` with no digits
  - more than 4 exponent digits
  - an empty string
  - a partial or extra WORD
- WORD results: sig=0, exp=0; sign is taken from the sign char.
- COMMIT: writes the record to `mem[addr]`, sets `semaphor[addr]`, clears `busy`, returns to IDLE.
- Read: `rddata <= mem[rdaddrs]` when `rden`; otherwise it holds.

## Timing
- Accept at edge t0. Char i is examined during cycle t0+1+i.
- Let k be the index of the terminating or invalid char; k=34 when no NUL is present. COMMIT occurs at edge t0+k+2. Maximum latency is 36 cycles.
- `busy` is high from t0 through the COMMIT edge inclusive. A `wren` in the COMMIT cycle is rejected with `overrun`; the earliest next accept is the cycle after COMMIT.
- Rejected `wren` does not alter the semaphore, the latched job, or memory.
- `ready` and `rddata` appear 1 cycle after `rden`.
- A read of the committing address in the COMMIT cycle returns `ready`=0 and old data.
- Reset values:
  - `ready`=1
  - `busy`=0
  - `overrun`=0
  - `rddata`=0
  - semaphore=16'hFFFF
  - state=IDLE
- Memory contents are not reset.
- Reset mid-job aborts the job with no commit; all semaphores return to 1.

## Test plan
- "-123.45e2" to addr 3 → commit at t0+11: class 00, sign 1, sig 12345, exp 0, invalid 0, inexact 0; `ready`=0 for reads before commit, 1 after.
- "0.00150" → sig 150, exp −5. "1" followed by 21 zeros → sig 10^19, exp +2, inexact 0. The same string with its last char changed to `1` → inexact 1.
- "snan", "-INF", "nan" → class 11/01/10 with sign 0/1/0. "nanx" and "1e12345" → qNaN, invalid 1.
- 34 digits with no NUL → commit at t0+36, `busy` high for the whole job. A `wren` at t0+5 → `overrun` pulse, target semaphore unchanged.
- Back-to-back: `wren` in the COMMIT cycle is rejected; `wren` the next cycle is accepted. Reads to both addresses return the correct records.
- Assert `RESET` low at t0+4 → `busy`=0 and `ready`=1 immediately; no commit ever occurs. The next job completes normally.
